// File: rtl/rx_word_packer.sv
// rx_word_packer: acquires lane alignment on a K28.5 comma, then packs decoded bytes into 8/16/32-bit words.
// Optional saturating invalid-symbol counter (errCnt) enabled by defining RX_WORD_PACKER_ERR_CNT_EN.
//
// state     | meaning
// UNALIGNED | waiting for a clean comma; data ignored
// ALIGNED   | packing data bytes; ERR_LIMIT consecutive invalids drop back to UNALIGNED
module rx_word_packer #(
    parameter logic [7:0] COMMA     = 8'hBC,
    parameter int         ERR_LIMIT = 4,
    parameter int         ERR_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [1:0]  dataS,
    input  logic [7:0]  dataIn,
    input  logic        k_in,
    input  logic        invalid_in,
    output logic [31:0] dataOut,
    output logic        validOut,
    output logic        aligned,
    output logic        errFlag
`ifdef RX_WORD_PACKER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] errCnt
`endif
);

    typedef enum logic [0:0] {
        UNALIGNED = 1'b0,
        ALIGNED   = 1'b1
    } state_t;

    state_t      state, nextState;
    logic [1:0]  index, nextIndex;
    logic [3:0]  errRun, nextErrRun, errRunInc;
    logic [1:0]  widthReg, nextWidth, effWidth;
    logic [1:0]  lastIdx;
    logic [31:0] bufReg, nextBuf, nextDataOut;
    logic        nextValid, nextErrFlag, isComma;

    assign aligned = (state == ALIGNED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= UNALIGNED;
            index    <= 2'd0;
            errRun   <= 4'd0;
            widthReg <= 2'd0;
            bufReg   <= 32'd0;
            dataOut  <= 32'd0;
            validOut <= 1'b0;
            errFlag  <= 1'b0;
        end else begin
            state    <= nextState;
            index    <= nextIndex;
            errRun   <= nextErrRun;
            widthReg <= nextWidth;
            bufReg   <= nextBuf;
            dataOut  <= nextDataOut;
            validOut <= nextValid;
            errFlag  <= nextErrFlag;
        end
    end

    always_comb begin
        nextState   = state;
        nextIndex   = index;
        nextErrRun  = errRun;
        nextBuf     = bufReg;
        nextDataOut = dataOut;
        nextValid   = 1'b0;
        nextErrFlag = 1'b0;
        // Width select is only honoured at a word boundary; mid-word the latched value rules.
        effWidth    = (index == 2'd0) ? dataS : widthReg;
        nextWidth   = enb ? effWidth : widthReg;
        case (effWidth)
            2'b01:   lastIdx = 2'd1;
            2'b10:   lastIdx = 2'd3;
            default: lastIdx = 2'd0;
        endcase
        isComma   = k_in && !invalid_in && (dataIn == COMMA);
        errRunInc = errRun + 4'd1;

        if (enb) begin
            case (state)
                UNALIGNED: begin
                    if (invalid_in) begin
                        nextErrFlag = 1'b1;
                    end else if (isComma) begin
                        nextState  = ALIGNED;
                        nextIndex  = 2'd0;
                        nextErrRun = 4'd0;
                    end
                end
                ALIGNED: begin
                    if (invalid_in) begin
                        nextErrFlag = 1'b1;
                        nextIndex   = 2'd0;
                        if (errRunInc == 4'(ERR_LIMIT)) begin
                            nextState  = UNALIGNED;
                            nextErrRun = 4'd0;
                        end else begin
                            nextErrRun = errRunInc;
                        end
                    end else if (isComma) begin
                        nextIndex  = 2'd0;
                        nextErrRun = 4'd0;
                    end else if (k_in) begin
                        nextErrRun = 4'd0;
                    end else begin
                        nextErrRun = 4'd0;
                        // Clearing at lane 0 keeps unused upper lanes at zero.
                        nextBuf = (index == 2'd0) ? 32'd0 : bufReg;
                        nextBuf[{index, 3'b000} +: 8] = dataIn;
                        if (index == lastIdx) begin
                            nextIndex   = 2'd0;
                            nextValid   = 1'b1;
                            nextDataOut = nextBuf;
                        end else begin
                            nextIndex = index + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef RX_WORD_PACKER_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errCnt <= '0;
        end else if (nextErrFlag && (errCnt != '1)) begin
            errCnt <= errCnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rx_word_packer.sv
// Self-checking bench for rx_word_packer: directed scenarios plus randomized symbols against a byte-queue model.
module tb_rx_word_packer;

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam int         ERR_LIMIT = 4;
    localparam int         ERR_CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enb = 1'b0;
    logic [1:0]  dataS = 2'b00;
    logic [7:0]  dataIn = 8'h00;
    logic        k_in = 1'b0;
    logic        invalid_in = 1'b0;
    logic [31:0] dataOut;
    logic        validOut;
    logic        aligned;
    logic        errFlag;
`ifdef RX_WORD_PACKER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] errCnt;
`endif

    int asserts  = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  mBytes[$];
    int          mWordLen = 1;
    bit          mAligned = 0;
    int          mErrRun = 0;
    int          mErrTotal = 0;
    logic [31:0] expData = 32'd0;
    bit          expValid = 0;
    bit          expErrFlag = 0;

    rx_word_packer #(
        .COMMA(COMMA),
        .ERR_LIMIT(ERR_LIMIT),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .dataS(dataS),
        .dataIn(dataIn),
        .k_in(k_in),
        .invalid_in(invalid_in),
        .dataOut(dataOut),
        .validOut(validOut),
        .aligned(aligned),
        .errFlag(errFlag)
`ifdef RX_WORD_PACKER_ERR_CNT_EN
        ,
        .errCnt(errCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mBytes.delete();
        mWordLen   = 1;
        mAligned   = 0;
        mErrRun    = 0;
        mErrTotal  = 0;
        expData    = 32'd0;
        expValid   = 0;
        expErrFlag = 0;
    endtask

    // Apply one symbol, update the model, return 1 time unit after the sampling edge.
    task automatic drive(input bit e, input bit [1:0] s, input bit [7:0] d, input bit k, input bit inv);
        bit isComma;
        enb = e; dataS = s; dataIn = d; k_in = k; invalid_in = inv;
        expValid   = 0;
        expErrFlag = 0;
        isComma = k && !inv && (d == COMMA);
        if (e) begin
            if (inv) begin
                expErrFlag = 1;
                mErrTotal++;
                if (mAligned) begin
                    mBytes.delete();
                    mErrRun++;
                    if (mErrRun >= ERR_LIMIT) begin
                        mAligned = 0;
                        mErrRun  = 0;
                    end
                end
            end else if (!mAligned) begin
                if (isComma) begin
                    mAligned = 1;
                    mErrRun  = 0;
                    mBytes.delete();
                end
            end else if (isComma) begin
                mBytes.delete();
                mErrRun = 0;
            end else if (k) begin
                mErrRun = 0;
            end else begin
                mErrRun = 0;
                if (mBytes.size() == 0) mWordLen = (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 1;
                mBytes.push_back(d);
                if (mBytes.size() == mWordLen) begin
                    expValid = 1;
                    expData  = 32'd0;
                    foreach (mBytes[i]) expData |= 32'(mBytes[i]) << (8 * i);
                    mBytes.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        enb = 1'b0;
        #3;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        asserts++;
        if ({dataOut, validOut, aligned, errFlag} !== 35'd0) begin
            failures++;
            $display("FAIL reset_initial: got dataOut=%h valid=%b aligned=%b err=%b, want all 0", dataOut, validOut, aligned, errFlag);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 2'b00, COMMA, 1, 0);
        drive(1, 2'b00, 8'h77, 0, 0);
        asserts++;
        if (dataOut !== 32'h77 || validOut !== 1'b1) begin
            failures++;
            $display("FAIL reset_preword: got dataOut=%h valid=%b, want 00000077/1", dataOut, validOut);
        end
        drive(1, 2'b01, 8'h55, 0, 0);
        #2 rst = 1'b0;
        #1;
        asserts++;
        if ({dataOut, validOut, aligned, errFlag} !== 35'd0) begin
            failures++;
            $display("FAIL reset_midstream: got dataOut=%h valid=%b aligned=%b err=%b, want all 0", dataOut, validOut, aligned, errFlag);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 2'b00, 8'h99, 0, 0);
        asserts++;
        if (aligned !== 1'b0 || validOut !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got aligned=%b valid=%b, want 0/0", aligned, validOut);
        end
    endtask

    task automatic test_8b();
        drive(1, 2'b00, COMMA, 1, 0);
        asserts++;
        if (aligned !== 1'b1 || validOut !== 1'b0) begin
            failures++;
            $display("FAIL 8b_align: got aligned=%b valid=%b, want 1/0", aligned, validOut);
        end
        drive(1, 2'b00, 8'h3C, 0, 0);
        asserts++;
        if (validOut !== 1'b1 || dataOut !== 32'h0000003C) begin
            failures++;
            $display("FAIL 8b_word0: got valid=%b dataOut=%h, want 1/0000003c", validOut, dataOut);
        end
        drive(1, 2'b00, 8'hA5, 0, 0);
        asserts++;
        if (validOut !== 1'b1 || dataOut !== 32'h000000A5) begin
            failures++;
            $display("FAIL 8b_word1: got valid=%b dataOut=%h, want 1/000000a5", validOut, dataOut);
        end
    endtask

    task automatic test_16b();
        logic [7:0]  bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [31:0] words[2] = '{32'h00002211, 32'h00004433};
        drive(1, 2'b01, COMMA, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b01, bytes[i], 0, 0);
            asserts++;
            if (validOut !== bit'(i % 2) || (i % 2 == 1 && dataOut !== words[i / 2])) begin
                failures++;
                $display("FAIL 16b_byte%0d: got valid=%b dataOut=%h, want valid=%0d dataOut=%h", i, validOut, dataOut, i % 2, words[i / 2]);
            end
        end
    endtask

    task automatic test_32b_realign();
        logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        int pulses = 0;
        drive(1, 2'b10, COMMA, 1, 0);
        drive(1, 2'b10, 8'h01, 0, 0);
        if (validOut) pulses++;
        drive(1, 2'b10, 8'h02, 0, 0);
        if (validOut) pulses++;
        drive(1, 2'b10, COMMA, 1, 0);
        if (validOut) pulses++;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b10, bytes[i], 0, 0);
            if (validOut) pulses++;
        end
        asserts++;
        if (pulses !== 1 || dataOut !== 32'hEFBEADDE) begin
            failures++;
            $display("FAIL 32b_realign: got pulses=%0d dataOut=%h, want 1/efbeadde", pulses, dataOut);
        end
    endtask

    task automatic test_loss_of_lock();
        drive(1, 2'b00, COMMA, 1, 0);
        for (int i = 0; i < ERR_LIMIT; i++) begin
            drive(1, 2'b00, 8'h00, 0, 1);
            asserts++;
            if (errFlag !== 1'b1 || aligned !== bit'(i < ERR_LIMIT - 1)) begin
                failures++;
                $display("FAIL lock_err%0d: got errFlag=%b aligned=%b, want 1/%0d", i, errFlag, aligned, i < ERR_LIMIT - 1);
            end
        end
        drive(1, 2'b00, 8'h12, 0, 0);
        drive(1, 2'b00, 8'h34, 0, 0);
        asserts++;
        if (validOut !== 1'b0 || aligned !== 1'b0) begin
            failures++;
            $display("FAIL lock_ignored: got valid=%b aligned=%b, want 0/0", validOut, aligned);
        end
        drive(1, 2'b00, COMMA, 1, 0);
        for (int i = 0; i < ERR_LIMIT - 1; i++) drive(1, 2'b00, 8'h00, 0, 1);
        drive(1, 2'b00, 8'h5A, 0, 0);
        asserts++;
        if (aligned !== 1'b1 || validOut !== 1'b1 || dataOut !== 32'h5A) begin
            failures++;
            $display("FAIL lock_keep: got aligned=%b valid=%b dataOut=%h, want 1/1/0000005a", aligned, validOut, dataOut);
        end
        drive(1, 2'b00, 8'h00, 0, 1);
        asserts++;
        if (aligned !== 1'b1) begin
            failures++;
            $display("FAIL lock_restart: got aligned=%b, want 1", aligned);
        end
    endtask

    task automatic test_enb_low();
        drive(1, 2'b00, COMMA, 1, 0);
        drive(1, 2'b00, 8'h6B, 0, 0);
        drive(0, 2'b00, 8'hC3, 0, 1);
        asserts++;
        if (validOut !== 1'b0 || errFlag !== 1'b0 || dataOut !== 32'h6B || aligned !== 1'b1) begin
            failures++;
            $display("FAIL enb_low: got valid=%b err=%b dataOut=%h aligned=%b, want 0/0/0000006b/1", validOut, errFlag, dataOut, aligned);
        end
    endtask

    task automatic test_width_change();
        drive(1, 2'b10, COMMA, 1, 0);
        drive(1, 2'b10, 8'h01, 0, 0);
        drive(1, 2'b00, 8'h02, 0, 0);
        drive(1, 2'b01, 8'h03, 0, 0);
        asserts++;
        if (validOut !== 1'b0) begin
            failures++;
            $display("FAIL width_midword: got valid=%b, want 0", validOut);
        end
        drive(1, 2'b00, 8'h04, 0, 0);
        asserts++;
        if (validOut !== 1'b1 || dataOut !== 32'h04030201) begin
            failures++;
            $display("FAIL width_hold: got valid=%b dataOut=%h, want 1/04030201", validOut, dataOut);
        end
        drive(1, 2'b00, 8'hAB, 0, 0);
        asserts++;
        if (validOut !== 1'b1 || dataOut !== 32'h000000AB) begin
            failures++;
            $display("FAIL width_next: got valid=%b dataOut=%h, want 1/000000ab", validOut, dataOut);
        end
    endtask

`ifdef RX_WORD_PACKER_ERR_CNT_EN
    task automatic test_err_cnt();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1, 2'b00, 8'h00, 0, 1);
        asserts++;
        if (errCnt !== ERR_CNT_W'(5)) begin
            failures++;
            $display("FAIL err_cnt: got errCnt=%0d, want 5", errCnt);
        end
    endtask
`endif

    task automatic test_random();
        bit         e, k, inv;
        bit [1:0]   s;
        bit [7:0]   d;
        int         sel;
        for (int n = 0; n < 600; n++) begin
            e   = ($urandom_range(0, 9) != 0);
            s   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 19);
            d   = 8'($urandom_range(0, 255));
            k   = 0;
            inv = 0;
            if (sel == 0) inv = 1;
            else if (sel == 1) begin k = 1; d = COMMA; end
            else if (sel == 2) begin k = 1; d = 8'h1C; end
            drive(e, s, d, k, inv);
            asserts++;
            if (validOut !== expValid || dataOut !== expData || aligned !== mAligned || errFlag !== expErrFlag) begin
                failures++;
                $display("FAIL random_%0d: got valid=%b data=%h aligned=%b err=%b, want %b/%h/%b/%b",
                         n, validOut, dataOut, aligned, errFlag, expValid, expData, mAligned, expErrFlag);
            end
`ifdef RX_WORD_PACKER_ERR_CNT_EN
            asserts++;
            if (errCnt !== ERR_CNT_W'(mErrTotal)) begin
                failures++;
                $display("FAIL random_errcnt_%0d: got %0d, want %0d", n, errCnt, mErrTotal);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_8b();
        test_16b();
        test_32b_realign();
        test_loss_of_lock();
        test_enb_low();
        test_width_change();
`ifdef RX_WORD_PACKER_ERR_CNT_EN
        test_err_cnt();
`endif
        apply_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
